// File: rtl/datapath_param_pkg.sv
// Shared encodings for datapath_param: ALU ops, in2 selects, FSM states and control-word layout.
// The control-word layout is fixed bits first, then three RW-wide register selects.
package datapath_param_pkg;

  localparam logic [2:0] AluAdd  = 3'd0;
  localparam logic [2:0] AluSub  = 3'd1;
  localparam logic [2:0] AluAnd  = 3'd2;
  localparam logic [2:0] AluOr   = 3'd3;
  localparam logic [2:0] AluXor  = 3'd4;
  localparam logic [2:0] AluNand = 3'd5;
  localparam logic [2:0] AluPass = 3'd6;
  localparam logic [2:0] AluShl1 = 3'd7;

  localparam logic [1:0] In2Bus = 2'd0;
  localparam logic [1:0] In2One = 2'd1;
  localparam logic [1:0] In2Two = 2'd2;
  localparam logic [1:0] In2Imm = 2'd3;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  localparam int unsigned CwPcLd      = 0;
  localparam int unsigned CwPcToA     = 1;
  localparam int unsigned CwT1Ld      = 2;
  localparam int unsigned CwT1ToA     = 3;
  localparam int unsigned CwT1ToB     = 4;
  localparam int unsigned CwT2Ld      = 5;
  localparam int unsigned CwT2ToA     = 6;
  localparam int unsigned CwT2ToB     = 7;
  localparam int unsigned CwDinToB    = 8;
  localparam int unsigned CwRfAEn     = 9;
  localparam int unsigned CwRfBEn     = 10;
  localparam int unsigned CwRfWe      = 11;
  localparam int unsigned CwRfWsrc    = 12;
  localparam int unsigned CwFlagLd    = 13;
  localparam int unsigned CwMemRd     = 14;
  localparam int unsigned CwMemWr     = 15;
  localparam int unsigned CwAddrFromB = 16;
  localparam int unsigned CwAluOp     = 17;  // 3 bits
  localparam int unsigned CwIn2Sel    = 20;  // 2 bits
  localparam int unsigned CwImm8      = 22;  // 8 bits
  localparam int unsigned CwRfASel    = 30;  // RW bits

  function automatic int unsigned cw_rf_b_sel(input int unsigned rw);
    return CwRfASel + rw;
  endfunction

  function automatic int unsigned cw_rf_dst(input int unsigned rw);
    return CwRfASel + 2 * rw;
  endfunction

  function automatic int unsigned cw_w(input int unsigned rw);
    return CwRfASel + 3 * rw;
  endfunction

endpackage

// File: rtl/datapath_param_alu.sv
// Combinational ALU producing result and {N,Z,C,V}.
// DATAPATH_PARAM_FULL_FLAGS_EN enables N/C/V; otherwise only Z is produced.
module datapath_param_alu
  import datapath_param_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic [2:0]    op,
  output logic [DW-1:0] result,
  output logic [3:0]    flags
);

`ifdef DATAPATH_PARAM_FULL_FLAGS_EN
  logic [DW:0] sum;
  logic [DW:0] diff;
  logic        c;
  logic        v;

  always_comb begin
    sum  = {1'b0, in1} + {1'b0, in2};
    // Subtract as in1 + ~in2 + 1 so the carry out is the NOT-borrow.
    diff = {1'b0, in1} + {1'b0, ~in2} + (DW + 1)'(1);
    c    = 1'b0;
    v    = 1'b0;
    unique case (op)
      AluAdd: begin
        result = sum[DW-1:0];
        c      = sum[DW];
        v      = (in1[DW-1] == in2[DW-1]) && (sum[DW-1] != in1[DW-1]);
      end
      AluSub: begin
        result = diff[DW-1:0];
        c      = diff[DW];
        v      = (in1[DW-1] != in2[DW-1]) && (diff[DW-1] != in1[DW-1]);
      end
      AluAnd:  result = in1 & in2;
      AluOr:   result = in1 | in2;
      AluXor:  result = in1 ^ in2;
      AluNand: result = ~(in1 & in2);
      AluPass: result = in2;
      AluShl1: begin
        result = {in1[DW-2:0], 1'b0};
        c      = in1[DW-1];
      end
    endcase
    flags = {result[DW-1], result == '0, c, v};
  end
`else
  always_comb begin
    unique case (op)
      AluAdd:  result = in1 + in2;
      AluSub:  result = in1 - in2;
      AluAnd:  result = in1 & in2;
      AluOr:   result = in1 | in2;
      AluXor:  result = in1 ^ in2;
      AluNand: result = ~(in1 & in2);
      AluPass: result = in2;
      AluShl1: result = {in1[DW-2:0], 1'b0};
    endcase
    flags = {1'b0, result == '0, 2'b00};
  end
`endif

endmodule

// File: rtl/datapath_param.sv
// Parametrised datapath: register file, T1/T2, PC, DIN, ALU, buses A/B and a req/ack memory port.
// Build with DATAPATH_PARAM_FULL_FLAGS_EN for N/C/V flags; default build keeps only Z.
module datapath_param
  import datapath_param_pkg::*;
#(
  parameter  int unsigned DW   = 16,
  parameter  int unsigned AW   = 16,
  parameter  int unsigned NREG = 32,
  localparam int unsigned RW   = $clog2(NREG),
  localparam int unsigned CW_W = cw_w(RW)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CW_W-1:0] cw,
  input  logic            cw_valid,
  output logic            cw_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack,
  output logic [3:0]      flags,
  output logic            bus_conflict
);

  localparam int unsigned RfBSel = cw_rf_b_sel(RW);
  localparam int unsigned RfDst  = cw_rf_dst(RW);

  logic [DW-1:0] pc_q, t1_q, t2_q, din_q;
  logic [DW-1:0] rf_q [NREG];
  logic [3:0]    flags_q;
  logic [0:0]    state_q;
  logic          mem_req_q, mem_we_q, conflict_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;

  logic [RW-1:0] rf_a_sel, rf_b_sel, rf_dst;
  logic [7:0]    imm8;
  logic [DW-1:0] bus_a, bus_b, in2, addr_bus, alu_result;
  logic [3:0]    alu_flags;
  logic          accepted, conflict_now;

  assign rf_a_sel = cw[CwRfASel +: RW];
  assign rf_b_sel = cw[RfBSel +: RW];
  assign rf_dst   = cw[RfDst +: RW];
  assign imm8     = cw[CwImm8 +: 8];

  assign cw_ready = (state_q == StIdle);
  assign accepted = cw_valid & cw_ready;

  always_comb begin
    bus_a = '0;
    if (cw[CwPcToA]) bus_a = bus_a | pc_q;
    if (cw[CwT1ToA]) bus_a = bus_a | t1_q;
    if (cw[CwT2ToA]) bus_a = bus_a | t2_q;
    if (cw[CwRfAEn]) bus_a = bus_a | rf_q[rf_a_sel];
    bus_b = '0;
    if (cw[CwT1ToB])  bus_b = bus_b | t1_q;
    if (cw[CwT2ToB])  bus_b = bus_b | t2_q;
    if (cw[CwDinToB]) bus_b = bus_b | din_q;
    if (cw[CwRfBEn])  bus_b = bus_b | rf_q[rf_b_sel];
    conflict_now = !$onehot0({cw[CwPcToA], cw[CwT1ToA], cw[CwT2ToA], cw[CwRfAEn]}) ||
                   !$onehot0({cw[CwT1ToB], cw[CwT2ToB], cw[CwDinToB], cw[CwRfBEn]});
    unique case (cw[CwIn2Sel +: 2])
      In2Bus: in2 = bus_b;
      In2One: in2 = DW'(1);
      In2Two: in2 = DW'(2);
      In2Imm: in2 = {{(DW - 8){imm8[7]}}, imm8};
    endcase
    addr_bus = cw[CwAddrFromB] ? bus_b : bus_a;
  end

  datapath_param_alu #(
    .DW(DW)
  ) u_alu (
    .in1   (bus_a),
    .in2   (in2),
    .op    (cw[CwAluOp +: 3]),
    .result(alu_result),
    .flags (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      t1_q       <= '0;
      t2_q       <= '0;
      flags_q    <= '0;
      conflict_q <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (accepted) begin
      if (cw[CwPcLd])   pc_q    <= bus_b;
      if (cw[CwT1Ld])   t1_q    <= alu_result;
      if (cw[CwT2Ld])   t2_q    <= bus_b;
      if (cw[CwFlagLd]) flags_q <= alu_flags;
      if (cw[CwRfWe])   rf_q[rf_dst] <= cw[CwRfWsrc] ? bus_b : alu_result;
      if (conflict_now) conflict_q <= 1'b1;
    end
  end

  // Memory FSM: request registered at accept, held until the ack pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      din_q       <= '0;
    end else if (state_q == StIdle) begin
      if (accepted && (cw[CwMemRd] || cw[CwMemWr])) begin
        state_q     <= StBusy;
        mem_req_q   <= 1'b1;
        mem_we_q    <= cw[CwMemWr];
        mem_addr_q  <= addr_bus[AW-1:0];
        mem_wdata_q <= bus_a;
      end
    end else if (mem_ack) begin
      state_q   <= StIdle;
      mem_req_q <= 1'b0;
      if (!mem_we_q) din_q <= mem_rdata;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign flags        = flags_q;
  assign bus_conflict = conflict_q;

endmodule

// File: tb/tb_datapath_param.sv
// Directed self-checking bench for datapath_param (DW=16, AW=16, NREG=32).
// Flag expectations follow DATAPATH_PARAM_FULL_FLAGS_EN when defined.
module tb_datapath_param;
  import datapath_param_pkg::*;

  localparam int unsigned RW     = 5;
  localparam int unsigned CW_W   = cw_w(RW);
  localparam int unsigned RfBSel = cw_rf_b_sel(RW);
  localparam int unsigned RfDst  = cw_rf_dst(RW);

`ifdef DATAPATH_PARAM_FULL_FLAGS_EN
  localparam logic [3:0] ExpSubZ = 4'b0110;
  localparam logic [3:0] ExpOvf  = 4'b1001;
  localparam logic [3:0] ExpNand = 4'b1000;
`else
  localparam logic [3:0] ExpSubZ = 4'b0100;
  localparam logic [3:0] ExpOvf  = 4'b0000;
  localparam logic [3:0] ExpNand = 4'b0000;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [CW_W-1:0] cw;
  logic            cw_valid;
  logic            cw_ready;
  logic            mem_req;
  logic            mem_we;
  logic [15:0]     mem_addr;
  logic [15:0]     mem_wdata;
  logic [15:0]     mem_rdata;
  logic            mem_ack;
  logic [3:0]      flags;
  logic            bus_conflict;

  int checks = 0;
  int errors = 0;

  datapath_param dut (
    .clk         (clk),
    .rst         (rst),
    .cw          (cw),
    .cw_valid    (cw_valid),
    .cw_ready    (cw_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .flags       (flags),
    .bus_conflict(bus_conflict)
  );

  always #5 clk = ~clk;

  // Present one control word for one clock edge, then sample 1 ns later.
  task automatic issue(input logic [CW_W-1:0] w);
    cw       = w;
    cw_valid = 1'b1;
    @(posedge clk);
    #1;
    cw_valid = 1'b0;
    cw       = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags); end
    checks++; if (bus_conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b want 0", bus_conflict); end
    checks++; if (cw_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cw_ready); end
  endtask

  task automatic test_imm_chain();
    logic [CW_W-1:0] w;
    w = '0;
    w[CwImm8 +: 8] = 8'h05; w[CwIn2Sel +: 2] = In2Imm; w[CwAluOp +: 3] = AluPass;
    w[CwFlagLd] = 1'b1; w[CwRfWe] = 1'b1; w[RfDst +: RW] = 5'd3;
    issue(w);
    checks++; if (dut.rf_q[3] !== 16'h0005) begin errors++; $display("FAIL imm_r3: got %h want 0005", dut.rf_q[3]); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL imm_flags: got %b want 0000", flags); end
    w = '0;
    w[CwRfAEn] = 1'b1; w[CwRfASel +: RW] = 5'd3; w[CwRfBEn] = 1'b1; w[RfBSel +: RW] = 5'd3;
    w[CwIn2Sel +: 2] = In2Bus; w[CwAluOp +: 3] = AluSub; w[CwFlagLd] = 1'b1;
    issue(w);
    checks++; if (flags !== ExpSubZ) begin errors++; $display("FAIL sub_flags: got %b want %b", flags, ExpSubZ); end
    checks++; if (bus_conflict !== 1'b0) begin errors++; $display("FAIL sub_conflict: got %b want 0", bus_conflict); end
  endtask

  // Builds R5 = 0x1234 via PASS imm, eight SHL1, then ADD imm.
  task automatic build_r5();
    logic [CW_W-1:0] w;
    w = '0;
    w[CwImm8 +: 8] = 8'h12; w[CwIn2Sel +: 2] = In2Imm; w[CwAluOp +: 3] = AluPass;
    w[CwRfWe] = 1'b1; w[RfDst +: RW] = 5'd5;
    issue(w);
    for (int i = 0; i < 8; i++) begin
      w = '0;
      w[CwRfAEn] = 1'b1; w[CwRfASel +: RW] = 5'd5; w[CwAluOp +: 3] = AluShl1;
      w[CwRfWe] = 1'b1; w[RfDst +: RW] = 5'd5;
      issue(w);
    end
    w = '0;
    w[CwRfAEn] = 1'b1; w[CwRfASel +: RW] = 5'd5; w[CwImm8 +: 8] = 8'h34;
    w[CwIn2Sel +: 2] = In2Imm; w[CwAluOp +: 3] = AluAdd; w[CwRfWe] = 1'b1; w[RfDst +: RW] = 5'd5;
    issue(w);
    checks++; if (dut.rf_q[5] !== 16'h1234) begin errors++; $display("FAIL build_r5: got %h want 1234", dut.rf_q[5]); end
  endtask

  task automatic test_read_wait();
    logic [CW_W-1:0] w, junk;
    w = '0;
    w[CwRfBEn] = 1'b1; w[RfBSel +: RW] = 5'd5; w[CwAddrFromB] = 1'b1; w[CwMemRd] = 1'b1;
    junk = '0;
    junk[CwPcToA] = 1'b1; junk[CwT1ToA] = 1'b1; junk[CwT1Ld] = 1'b1;
    issue(w);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h1234 || cw_ready !== 1'b0 || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL read_busy[%0d]: got req=%b addr=%h ready=%b we=%b want 1 1234 0 0",
                 i, mem_req, mem_addr, cw_ready, mem_we);
      end
      if (i == 1) begin cw = junk; cw_valid = 1'b1; end
      if (i == 2) begin cw = '0; cw_valid = 1'b0; end
      if (i == 3) begin mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL read_done_req: got %b want 0", mem_req); end
    checks++; if (cw_ready !== 1'b1) begin errors++; $display("FAIL read_done_ready: got %b want 1", cw_ready); end
    checks++; if (dut.din_q !== 16'hBEEF) begin errors++; $display("FAIL read_din: got %h want beef", dut.din_q); end
    checks++; if (bus_conflict !== 1'b0) begin errors++; $display("FAIL busy_ignored: got %b want 0", bus_conflict); end
    w = '0;
    w[CwDinToB] = 1'b1; w[CwT2Ld] = 1'b1;
    issue(w);
    checks++; if (dut.t2_q !== 16'hBEEF) begin errors++; $display("FAIL t2_din: got %h want beef", dut.t2_q); end
  endtask

  task automatic test_overflow();
    logic [CW_W-1:0] w;
    // Zero-wait read of 0x7FFF: ack during the first request cycle.
    w = '0;
    w[CwMemRd] = 1'b1;
    issue(w);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL zw_req: got %b want 1", mem_req); end
    mem_ack = 1'b1; mem_rdata = 16'h7FFF;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0 || cw_ready !== 1'b1) begin errors++; $display("FAIL zw_done: got req=%b ready=%b want 0 1", mem_req, cw_ready); end
    checks++; if (dut.din_q !== 16'h7FFF) begin errors++; $display("FAIL zw_din: got %h want 7fff", dut.din_q); end
    w = '0;
    w[CwDinToB] = 1'b1; w[CwT2Ld] = 1'b1;
    issue(w);
    w = '0;
    w[CwT2ToA] = 1'b1; w[CwIn2Sel +: 2] = In2One; w[CwAluOp +: 3] = AluAdd;
    w[CwFlagLd] = 1'b1; w[CwRfWe] = 1'b1; w[RfDst +: RW] = 5'd4;
    issue(w);
    checks++; if (dut.rf_q[4] !== 16'h8000) begin errors++; $display("FAIL ovf_result: got %h want 8000", dut.rf_q[4]); end
    checks++; if (flags !== ExpOvf) begin errors++; $display("FAIL ovf_flags: got %b want %b", flags, ExpOvf); end
    w = '0;
    w[CwT2ToA] = 1'b1; w[CwImm8 +: 8] = 8'hFF; w[CwIn2Sel +: 2] = In2Imm;
    w[CwAluOp +: 3] = AluNand; w[CwFlagLd] = 1'b1; w[CwT1Ld] = 1'b1;
    issue(w);
    checks++; if (dut.t1_q !== 16'h8000) begin errors++; $display("FAIL nand_t1: got %h want 8000", dut.t1_q); end
    checks++; if (flags !== ExpNand) begin errors++; $display("FAIL nand_flags: got %b want %b", flags, ExpNand); end
  endtask

  task automatic test_write();
    logic [CW_W-1:0] w;
    w = '0;
    w[CwRfAEn] = 1'b1; w[CwRfASel +: RW] = 5'd4; w[CwT2ToB] = 1'b1;
    w[CwAddrFromB] = 1'b1; w[CwMemWr] = 1'b1; w[CwMemRd] = 1'b1;
    issue(w);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_we: got %b want 1", mem_we); end
    checks++; if (mem_addr !== 16'h7FFF) begin errors++; $display("FAIL wr_addr: got %h want 7fff", mem_addr); end
    checks++; if (mem_wdata !== 16'h8000) begin errors++; $display("FAIL wr_wdata: got %h want 8000", mem_wdata); end
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    checks++; if (dut.din_q !== 16'h7FFF || mem_req !== 1'b0) begin errors++; $display("FAIL wr_done: got din=%h req=%b want 7fff 0", dut.din_q, mem_req); end
  endtask

  task automatic test_conflict();
    logic [CW_W-1:0] w;
    w = '0;
    w[CwPcToA] = 1'b1; w[CwT1ToA] = 1'b1;
    issue(w);
    checks++; if (bus_conflict !== 1'b1) begin errors++; $display("FAIL conflict_set: got %b want 1", bus_conflict); end
    issue('0);
    issue('0);
    checks++; if (bus_conflict !== 1'b1) begin errors++; $display("FAIL conflict_sticky: got %b want 1", bus_conflict); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (bus_conflict !== 1'b0) begin errors++; $display("FAIL conflict_clear: got %b want 0", bus_conflict); end
  endtask

  task automatic test_busy_reset();
    logic [CW_W-1:0] w;
    w = '0;
    w[CwMemRd] = 1'b1;
    issue(w);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL br_req: got %b want 1", mem_req); end
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(posedge clk);
    #1;
    rst = 1'b0; mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0 || cw_ready !== 1'b1) begin errors++; $display("FAIL br_abandon: got req=%b ready=%b want 0 1", mem_req, cw_ready); end
    checks++; if (dut.din_q !== 16'h0000) begin errors++; $display("FAIL br_din: got %h want 0000", dut.din_q); end
    mem_ack = 1'b1; mem_rdata = 16'hCAFE;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    checks++; if (dut.din_q !== 16'h0000 || mem_req !== 1'b0) begin errors++; $display("FAIL br_late_ack: got din=%h req=%b want 0000 0", dut.din_q, mem_req); end
  endtask

  initial begin
    rst       = 1'b1;
    cw        = '0;
    cw_valid  = 1'b0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    test_reset();
    test_imm_chain();
    build_r5();
    test_read_wait();
    test_overflow();
    test_write();
    test_conflict();
    test_busy_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
